dcdl_dcw_sched: RTL

//  Per-cycle scheduler for the 12-bit DCDL delay-control word (DCW) in the fractional output divider.

---
 rtl/dcdl_pkg.sv | 13 +
 rtl/dcw_gain_mult.sv | 49 ++++
 rtl/dcdl_dcw_sched.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dcdl_pkg.sv
// Shared types and constants for the DCDL delay-control-word scheduler.
package dcdl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } dcw_st_e;

  localparam int              DCW_W   = 12;
  localparam logic [DCW_W-1:0] DCW_MAX = 12'hFFF;

endpackage

// File: rtl/dcw_gain_mult.sv
// Registered phase-times-gain multiply: scales the residual phase by the DTC
// gain, keeps the integer part and saturates it to the 12-bit DCW range.
module dcw_gain_mult
  import dcdl_pkg::*;
#(
  parameter int FRAC_W = 16,
  parameter int KDTC_W = 14
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              vld_i,
  input  logic [FRAC_W-1:0] ph_i,
  input  logic [KDTC_W-1:0] gain_i,
  output logic [DCW_W-1:0]  dcw_o,
  output logic              vld_o
);

  logic [FRAC_W+KDTC_W-1:0] prod;
  logic [KDTC_W+DCW_W-1:0]  prod_hi;
  logic [DCW_W-1:0]         dcw_d;
  logic [DCW_W-1:0]         dcw_q;
  logic                     vld_q;

  // Full-width unsigned product, drop the fractional bits, clamp to DCW_MAX.
  always_comb begin
    prod    = {{KDTC_W{1'b0}}, ph_i} * {{FRAC_W{1'b0}}, gain_i};
    prod_hi = {{DCW_W{1'b0}}, prod[FRAC_W +: KDTC_W]};
    dcw_d   = (prod_hi > {{KDTC_W{1'b0}}, DCW_MAX}) ? DCW_MAX : prod_hi[DCW_W-1:0];
  end

  // Output register: DCW is only non-zero while it carries a scheduled sample.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      dcw_q <= '0;
      vld_q <= 1'b0;
    end else if (vld_i) begin
      dcw_q <= dcw_d;
      vld_q <= 1'b1;
    end else begin
      dcw_q <= '0;
      vld_q <= 1'b0;
    end
  end

  assign dcw_o = dcw_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/dcdl_dcw_sched.sv
// Per-cycle DCW scheduler: fractional phase accumulator producing DIV_N and
// a gain-scaled residual phase (DCW), with sign-sign LMS calibration of KDTC.
module dcdl_dcw_sched
  import dcdl_pkg::*;
#(
  parameter int          FRAC_W  = 16,
  parameter int          INT_W   = 8,
  parameter int          KDTC_W  = 14,
  parameter int unsigned MU_STEP = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [INT_W-1:0]  FCW_I,
  input  logic [FRAC_W-1:0] FCW_F,
  input  logic [KDTC_W-1:0] KDTC_INIT,
  input  logic              CAL_EN,
  input  logic              PHE_VLD,
  input  logic              PHE_SGN,
  output logic [DCW_W-1:0]  DCW,
  output logic              DCW_VLD,
  output logic [INT_W-1:0]  DIV_N,
  output logic [KDTC_W-1:0] KDTC,
  output logic              BUSY
);

  localparam logic [KDTC_W-1:0] KDTC_MAX = '1;
  localparam logic [KDTC_W-1:0] MU       = KDTC_W'(MU_STEP);

  dcw_st_e             state_q, state_d;
  logic [INT_W-1:0]    fcw_i_q;
  logic [FRAC_W-1:0]   fcw_f_q;
  logic [FRAC_W-1:0]   acc_q;
  logic [FRAC_W:0]     sum;
  logic [FRAC_W-1:0]   ph1_q;
  logic                s1_vld_q;
  logic [INT_W-1:0]    div_n_q;
  logic [KDTC_W-1:0]   kdtc_q, kdtc_d;
  logic [1:0]          msb_q;
  logic                run_go;
  logic                mult_vld;

  assign run_go   = (state_q == RUN) && EN;
  assign mult_vld = s1_vld_q && run_go;
  assign sum      = {1'b0, acc_q} + {1'b0, fcw_f_q};

  // Next-state logic for the IDLE/LOAD/RUN controller.
  always_comb begin
    // NOTE: default assigned first so every path drives state_d (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (EN) state_d = LOAD;
      LOAD:    state_d = EN ? RUN : IDLE;
      RUN:     if (!EN) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Stage 1: latch the FCW on LOAD, then accumulate phase and emit DIV_N.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fcw_i_q  <= '0;
      fcw_f_q  <= '0;
      acc_q    <= '0;
      ph1_q    <= '0;
      s1_vld_q <= 1'b0;
      div_n_q  <= '0;
    end else begin
      if (state_q == LOAD) begin
        fcw_i_q <= FCW_I;
        fcw_f_q <= FCW_F;
        acc_q   <= '0;
      end
      if (run_go) begin
        acc_q    <= sum[FRAC_W-1:0];
        ph1_q    <= sum[FRAC_W-1:0];
        s1_vld_q <= 1'b1;
        div_n_q  <= fcw_i_q + {{(INT_W-1){1'b0}}, sum[FRAC_W]};
      end else begin
        s1_vld_q <= 1'b0;
        div_n_q  <= '0;
      end
    end
  end

  // Stage 2: phase times gain, saturated to the DCW range.
  dcw_gain_mult #(
    .FRAC_W (FRAC_W),
    .KDTC_W (KDTC_W)
  ) u_mult (
    .CLK    (CLK),
    .RST    (RST),
    .vld_i  (mult_vld),
    .ph_i   (ph1_q),
    .gain_i (kdtc_q),
    .dcw_o  (DCW),
    .vld_o  (DCW_VLD)
  );

  // Phase MSB of the DCW on the output ([0]) and of the one before it ([1]);
  // the detector result lines up with [1].
  always_ff @(posedge CLK) begin
    if (RST) msb_q <= '0;
    else     msb_q <= {msb_q[0], ph1_q[FRAC_W-1] & mult_vld};
  end

  // Gain: load on LOAD, sign-sign LMS step on upper-half phases, saturating.
  always_comb begin
    kdtc_d = kdtc_q;
    if (state_q == LOAD) begin
      kdtc_d = KDTC_INIT;
    end else if ((state_q == RUN) && CAL_EN && PHE_VLD && msb_q[1]) begin
      if (PHE_SGN) kdtc_d = (kdtc_q > KDTC_MAX - MU) ? KDTC_MAX : kdtc_q + MU;
      else         kdtc_d = (kdtc_q < MU) ? '0 : kdtc_q - MU;
    end
  end

  // Gain register.
  always_ff @(posedge CLK) begin
    if (RST) kdtc_q <= '0;
    else     kdtc_q <= kdtc_d;
  end

  assign DIV_N = div_n_q;
  assign KDTC  = kdtc_q;
  assign BUSY  = (state_q != IDLE);

endmodule
